mad_io_port_ctrl: RTL and testbench
===================================

// Module: mad_io_port_ctrl
// PURPOSE
//  Peripheral at the far end of the mad_risc_processor I/O interface. It drives the core's In
//  bus from a host-fed input FIFO and captures words the core writes on Out into an output FIFO
//  that the host drains. It raises Int for the core when new input data arrives.
//  It sits between the processor top level and the host/testbench world.
// PARAMETERS
//  DATA_W     16  width of In/Out and host data
//  IN_DEPTH    8  input FIFO entries (power of 2, >=2)
//  OUT_DEPTH   8  output FIFO entries (power of 2, >=2)
//  INT_CYCLES  2  cycles Int stays high per interrupt request (>=1)
// PORTS
//  Clk            in   1       single clock; all state updates on rising edge
//  Rst            in   1       synchronous, active-high reset
//  host_wr_en     in   1       host pushes host_wr_data into input FIFO
//  host_wr_data   in   DATA_W  word for core
//  host_full      out  1       input FIFO full
//  In             out  DATA_W  to core In; head of input FIFO, 0 when empty
//  in_rd          in   1       core consumed In this cycle (IN instruction strobe)
//  in_empty       out  1       input FIFO empty
//  Out            in   DATA_W  from core Out
//  out_wr         in   1       core wrote Out this cycle (OUT instruction strobe)
//  out_full       out  1       output FIFO full
//  host_rd_en     in   1       host pops output FIFO
//  host_rd_data   out  DATA_W  head of output FIFO, 0 when empty
//  host_empty     out  1       output FIFO empty
//  int_en         in   1       interrupt generation enable
//  Int            out  1       interrupt to core
//  in_underflow   out  1       sticky: in_rd seen while empty
//  out_overflow   out  1       sticky: out_wr dropped because full
// BEHAVIOUR
//  Reset (Rst=1 at edge): both FIFOs emptied, pointers/counts 0; In=0, host_rd_data=0,
//   in_empty=1, host_empty=1, host_full=0, out_full=0, Int=0, sticky flags 0, IRQ FSM=IDLE.
//   Reset mid-operation discards all queued words and aborts any Int pulse in that cycle.
//  FIFOs: first-word-fall-through; In/host_rd_data are combinational from head entry, so a word
//   pushed at edge N is visible on In after edge N. Pointers wrap modulo depth; count
//   0..DEPTH, full = (count==DEPTH), empty = (count==0).
//  Push when full: ignored unless a pop occurs the same cycle, then both occur (count unchanged).
//  Pop when empty: ignored (also when a push occurs that cycle); in_rd on empty sets in_underflow.
//  Push+pop same cycle when neither boundary blocks: both occur, count unchanged.
//  out_wr while out_full and no host_rd_en: word lost, out_overflow set. Sticky flags clear only on Rst.
//  IRQ FSM (states IDLE, PULSE, ARMED_WAIT):
//   IDLE -> PULSE when int_en=1 and input FIFO count goes 0 -> nonzero at this edge
//    (push accepted while empty); Int=1 from next cycle, counter loaded INT_CYCLES-1.
//   PULSE: Int=1; counter decrements; at 0 -> ARMED_WAIT, Int=0.
//   ARMED_WAIT: Int=0; -> IDLE once input FIFO is empty. No new interrupt until re-armed.
//   int_en dropping to 0 in PULSE ends pulse next edge (-> ARMED_WAIT). int_en does not gate FIFOs.
//  Latency: host push -> In valid 1 cycle; host push into empty FIFO -> Int high 1 cycle later.
// TESTING
//  Reset: Rst=1 two cycles with host_wr_en=1 -> FIFOs stay empty, In=0, Int=0, flags 0.
//  Stream: push 0x0005,0x0019,0xFFFF,0xF320; pulse in_rd 4x -> In shows them in order, then 0, in_empty=1.
//  Int: int_en=1, push 0xAABD into empty FIFO -> Int high exactly 2 cycles; 2nd push no Int; drain, push -> Int again.
//  Full: push 9 words (depth 8) -> 9th dropped, host_full=1; push+in_rd same cycle when full -> both occur, count stays 8.
//  Output: out_wr with Out=0x1234,0x5678 -> host_rd_data=0x1234, host_rd_en -> 0x5678; 9th out_wr when full -> out_overflow=1.
//  Edges: in_rd on empty -> in_underflow=1, no pointer move; Rst during Int pulse -> Int=0 next cycle.

Source files
------------

// File: rtl/mad_io_port_ctrl.sv
// I/O peripheral for mad_risc_processor: host-fed input FIFO driving In, output FIFO
// capturing Out, and a one-shot interrupt raised when input data arrives in an empty FIFO.

module mad_io_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         push_ok_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          pop_ok_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_o = push_i && (!full_o || pop_ok_s);
  assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok_o, pop_ok_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end
endmodule

module mad_io_port_ctrl #(
  parameter int DATA_W     = 16,
  parameter int IN_DEPTH   = 8,
  parameter int OUT_DEPTH  = 8,
  parameter int INT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              host_wr_en,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_full,
  output logic [DATA_W-1:0] In,
  input  logic              in_rd,
  output logic              in_empty,
  input  logic [DATA_W-1:0] Out,
  input  logic              out_wr,
  output logic              out_full,
  input  logic              host_rd_en,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              host_empty,
  input  logic              int_en,
  output logic              Int,
  output logic              in_underflow,
  output logic              out_overflow
);
  localparam int CNT_W = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;

  typedef enum logic [1:0] {IRQ_IDLE, IRQ_PULSE, IRQ_ARMED} irq_state_e;

  irq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_push_ok_s;
  logic             out_push_ok_s;
  logic             in_underflow_q, out_overflow_q;

  mad_io_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .push_i    (host_wr_en),
    .data_i    (host_wr_data),
    .pop_i     (in_rd),
    .head_o    (In),
    .full_o    (host_full),
    .empty_o   (in_empty),
    .push_ok_o (in_push_ok_s)
  );

  mad_io_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .push_i    (out_wr),
    .data_i    (Out),
    .pop_i     (host_rd_en),
    .head_o    (host_rd_data),
    .full_o    (out_full),
    .empty_o   (host_empty),
    .push_ok_o (out_push_ok_s)
  );

  assign Int          = (state_q == IRQ_PULSE);
  assign in_underflow = in_underflow_q;
  assign out_overflow = out_overflow_q;

  // Arrival in an empty FIFO fires once; re-armed only after the FIFO drains.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IRQ_IDLE: begin
        if (int_en && in_empty && in_push_ok_s) begin
          state_d = IRQ_PULSE;
          cnt_d   = CNT_W'(INT_CYCLES - 1);
        end else begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_PULSE: begin
        if (!int_en || (cnt_q == '0)) begin
          state_d = IRQ_ARMED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      IRQ_ARMED: begin
        if (in_empty) state_d = IRQ_IDLE;
        else          state_d = IRQ_ARMED;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= IRQ_IDLE;
      cnt_q          <= '0;
      in_underflow_q <= 1'b0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      in_underflow_q <= in_underflow_q | (in_rd & in_empty);
      out_overflow_q <= out_overflow_q | (out_wr & ~out_push_ok_s);
    end
  end
endmodule

// File: tb/tb_mad_io_port_ctrl.sv
// Directed-vector bench for mad_io_port_ctrl with hand-computed expectations.

module tb_mad_io_port_ctrl;
  logic        Clk = 1'b0;
  logic        Rst, host_wr_en, in_rd, out_wr, host_rd_en, int_en;
  logic [15:0] host_wr_data, Out;
  logic        host_full, in_empty, out_full, host_empty, Int, in_underflow, out_overflow;
  logic [15:0] In, host_rd_data;
  int          vectors = 0;
  int          miscompares = 0;

  mad_io_port_ctrl dut (
    .Clk(Clk), .Rst(Rst), .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
    .host_full(host_full), .In(In), .in_rd(in_rd), .in_empty(in_empty), .Out(Out),
    .out_wr(out_wr), .out_full(out_full), .host_rd_en(host_rd_en),
    .host_rd_data(host_rd_data), .host_empty(host_empty), .int_en(int_en), .Int(Int),
    .in_underflow(in_underflow), .out_overflow(out_overflow)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b1; host_wr_en = 1'b1; host_wr_data = 16'h1111; in_rd = 1'b0;
    out_wr = 1'b0; Out = 16'h0000; host_rd_en = 1'b0; int_en = 1'b0;
    #1;
    // reset with a push held active
    tick(); tick();
    chk("rst_in_empty", {15'd0, in_empty}, 16'd1);
    chk("rst_In", In, 16'h0000);
    chk("rst_Int", {15'd0, Int}, 16'd0);
    chk("rst_host_full", {15'd0, host_full}, 16'd0);
    chk("rst_host_empty", {15'd0, host_empty}, 16'd1);
    chk("rst_out_full", {15'd0, out_full}, 16'd0);
    chk("rst_host_rd_data", host_rd_data, 16'h0000);
    chk("rst_flags", {14'd0, in_underflow, out_overflow}, 16'd0);
    Rst = 1'b0; host_wr_en = 1'b0;
    tick();

    // stream four words through In
    host_wr_en = 1'b1; host_wr_data = 16'h0005; tick();
    chk("stream_first_visible", In, 16'h0005);
    host_wr_data = 16'h0019; tick();
    host_wr_data = 16'hFFFF; tick();
    host_wr_data = 16'hF320; tick();
    host_wr_en = 1'b0;
    chk("stream_not_empty", {15'd0, in_empty}, 16'd0);
    in_rd = 1'b1;
    chk("stream_0", In, 16'h0005); tick();
    chk("stream_1", In, 16'h0019); tick();
    chk("stream_2", In, 16'hFFFF); tick();
    chk("stream_3", In, 16'hF320); tick();
    in_rd = 1'b0;
    chk("stream_drained_In", In, 16'h0000);
    chk("stream_drained_empty", {15'd0, in_empty}, 16'd1);
    chk("stream_no_int", {15'd0, Int}, 16'd0);
    chk("stream_no_underflow", {15'd0, in_underflow}, 16'd0);

    // interrupt pulse, no re-trigger until drained
    int_en = 1'b1;
    host_wr_en = 1'b1; host_wr_data = 16'hAABD; tick();
    host_wr_en = 1'b0;
    chk("int_cycle1", {15'd0, Int}, 16'd1);
    chk("int_In", In, 16'hAABD);
    tick();
    chk("int_cycle2", {15'd0, Int}, 16'd1);
    tick();
    chk("int_end", {15'd0, Int}, 16'd0);
    host_wr_en = 1'b1; host_wr_data = 16'h0001; tick();
    host_wr_en = 1'b0;
    chk("int_second_push_a", {15'd0, Int}, 16'd0);
    tick();
    chk("int_second_push_b", {15'd0, Int}, 16'd0);
    in_rd = 1'b1; tick(); tick();
    in_rd = 1'b0;
    chk("int_drained", {15'd0, in_empty}, 16'd1);
    tick();
    host_wr_en = 1'b1; host_wr_data = 16'h0042; tick();
    host_wr_en = 1'b0;
    chk("int_rearm_cycle1", {15'd0, Int}, 16'd1);
    tick();
    chk("int_rearm_cycle2", {15'd0, Int}, 16'd1);
    tick();
    chk("int_rearm_end", {15'd0, Int}, 16'd0);
    in_rd = 1'b1; tick();
    in_rd = 1'b0; int_en = 1'b0;
    chk("int_final_drain", {15'd0, in_empty}, 16'd1);

    // fill the input FIFO, overflow push, then push+pop at full
    host_wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_wr_data = 16'h0100 + 16'(i);
      tick();
    end
    chk("full_after_8", {15'd0, host_full}, 16'd1);
    host_wr_data = 16'h0108; tick();
    chk("full_9th_dropped_head", In, 16'h0100);
    chk("full_still_full", {15'd0, host_full}, 16'd1);
    host_wr_data = 16'h0200; in_rd = 1'b1; tick();
    host_wr_en = 1'b0;
    chk("full_pushpop_full", {15'd0, host_full}, 16'd1);
    chk("full_pushpop_head", In, 16'h0101);
    for (int i = 1; i < 8; i++) begin
      chk("full_drain", In, 16'h0100 + 16'(i));
      tick();
    end
    chk("full_drain_last", In, 16'h0200);
    tick();
    in_rd = 1'b0;
    chk("full_drained", {15'd0, in_empty}, 16'd1);
    chk("full_no_underflow", {15'd0, in_underflow}, 16'd0);

    // output FIFO capture and overflow
    out_wr = 1'b1; Out = 16'h1234; tick();
    Out = 16'h5678; tick();
    out_wr = 1'b0;
    chk("out_head", host_rd_data, 16'h1234);
    chk("out_not_empty", {15'd0, host_empty}, 16'd0);
    host_rd_en = 1'b1; tick();
    chk("out_second", host_rd_data, 16'h5678);
    tick();
    host_rd_en = 1'b0;
    chk("out_empty_data", host_rd_data, 16'h0000);
    chk("out_empty_flag", {15'd0, host_empty}, 16'd1);
    out_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Out = 16'h3000 + 16'(i);
      tick();
    end
    chk("out_full", {15'd0, out_full}, 16'd1);
    chk("out_no_overflow_yet", {15'd0, out_overflow}, 16'd0);
    Out = 16'h3008; tick();
    out_wr = 1'b0;
    chk("out_overflow", {15'd0, out_overflow}, 16'd1);
    chk("out_overflow_head", host_rd_data, 16'h3000);
    host_rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("out_drain", host_rd_data, 16'h3000 + 16'(i));
      tick();
    end
    host_rd_en = 1'b0;
    chk("out_drained", {15'd0, host_empty}, 16'd1);
    chk("out_overflow_sticky", {15'd0, out_overflow}, 16'd1);

    // underflow leaves pointers alone
    in_rd = 1'b1; tick();
    in_rd = 1'b0;
    chk("uf_flag", {15'd0, in_underflow}, 16'd1);
    chk("uf_empty", {15'd0, in_empty}, 16'd1);
    chk("uf_In", In, 16'h0000);
    host_wr_en = 1'b1; host_wr_data = 16'h0077; tick();
    host_wr_en = 1'b0;
    chk("uf_push_after", In, 16'h0077);
    chk("uf_sticky", {15'd0, in_underflow}, 16'd1);
    in_rd = 1'b1; tick();
    in_rd = 1'b0; tick();

    // reset aborts an interrupt pulse
    int_en = 1'b1;
    host_wr_en = 1'b1; host_wr_data = 16'h0055; tick();
    host_wr_en = 1'b0;
    chk("rstpulse_int_on", {15'd0, Int}, 16'd1);
    Rst = 1'b1; tick();
    chk("rstpulse_int_off", {15'd0, Int}, 16'd0);
    chk("rstpulse_empty", {15'd0, in_empty}, 16'd1);
    chk("rstpulse_flags", {14'd0, in_underflow, out_overflow}, 16'd0);
    Rst = 1'b0; tick();
    chk("rstpulse_int_stays_off", {15'd0, Int}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
